// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/forwarding controller:
// forward-select encodings, the per-stage record type and small helpers.
package hazard_ctrl_pkg;

    localparam int AW = 5;
    localparam int TW = 2;

    // Forward-mux select encodings (shared by D-stage and E-stage selects).
    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_E  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;
    localparam logic [1:0] FWD_W  = 2'b11;

    // Tuse value meaning "this instruction reads no operand".
    localparam logic [TW-1:0] TUSE_NONE = 2'b11;

    // One in-flight instruction as seen by the hazard logic.
    typedef struct packed {
        logic [AW-1:0] rs;
        logic [AW-1:0] rt;
        logic [AW-1:0] a3;
        logic          we;
        logic [TW-1:0] tnew;
    } stage_rec_t;

    // How a record's tnew field is transformed when the record loads.
    typedef enum logic [1:0] {
        TNEW_KEEP = 2'b00,
        TNEW_DEC  = 2'b01,
        TNEW_CLR  = 2'b10
    } tnew_op_e;

    localparam stage_rec_t REC_ZERO = '0;

    // Saturating decrement: the remaining-cycles count never wraps below zero.
    function automatic logic [TW-1:0] sat_dec(input logic [TW-1:0] x);
        logic [TW-1:0] res;
        if (x == {TW{1'b0}}) begin
            res = {TW{1'b0}};
        end else begin
            res = x - {{(TW-1){1'b0}}, 1'b1};
        end
        return res;
    endfunction

    // A stage produces register r when it writes r; $0 is hardwired and never produced.
    function automatic logic rec_match(input stage_rec_t rec, input logic [AW-1:0] r);
        return rec.we && (rec.a3 == r) && (r != {AW{1'b0}});
    endfunction

endpackage

// File: rtl/hazard_stage_rec.sv
// One pipeline-stage record register (E, M or W) with async reset,
// load/hold, bubble insertion and a configurable tnew update on load.
import hazard_ctrl_pkg::*;

module hazard_stage_rec (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic       bubble,
    input  tnew_op_e   tnew_op,
    input  stage_rec_t rec_in,
    output stage_rec_t rec_out
);

    stage_rec_t rec_d;
    stage_rec_t rec_q;

    // Next record: a bubble wins over a load; otherwise hold.
    always_comb begin
        rec_d = rec_q;
        if (bubble) begin
            rec_d = REC_ZERO;
        end else if (load) begin
            rec_d = rec_in;
            case (tnew_op)
                TNEW_KEEP: rec_d.tnew = rec_in.tnew;
                TNEW_DEC:  rec_d.tnew = sat_dec(rec_in.tnew);
                TNEW_CLR:  rec_d.tnew = {TW{1'b0}};
                default:   rec_d.tnew = rec_in.tnew;
            endcase
        end else begin
            rec_d = rec_q;
        end
    end

    // Record storage; reset clears every field immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rec_q <= REC_ZERO;
        end else begin
            rec_q <= rec_d;
        end
    end

    assign rec_out = rec_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and forwarding controller for the 5-stage pipeline: tracks the
// E/M/W producers and derives stall plus D- and E-stage forward selects.
import hazard_ctrl_pkg::*;

module hazard_ctrl (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] rs_d,
    input  logic [AW-1:0] rt_d,
    input  logic          use_rs_d,
    input  logic          use_rt_d,
    input  logic [TW-1:0] tuse_d,
    input  logic [TW-1:0] tnew_d,
    input  logic          we_d,
    input  logic [AW-1:0] a3_d,
    output logic          stall,
    output logic [1:0]    fwd_rs_d,
    output logic [1:0]    fwd_rt_d,
    output logic [1:0]    fwd_rs_e,
    output logic [1:0]    fwd_rt_e
);

    stage_rec_t e_in_s;
    stage_rec_t e_rec_s;
    stage_rec_t m_rec_s;
    stage_rec_t w_rec_s;
    logic       stall_rs_s;
    logic       stall_rt_s;

    // D-stage selector: youngest ready producer wins (E, then M, then W).
    function automatic logic [1:0] fwd_sel_d(input stage_rec_t e, input stage_rec_t m,
                                             input stage_rec_t w, input logic [AW-1:0] r);
        logic [1:0] sel;
        if (rec_match(e, r) && (e.tnew == {TW{1'b0}})) begin
            sel = FWD_E;
        end else if (rec_match(m, r) && (m.tnew == {TW{1'b0}})) begin
            sel = FWD_M;
        end else if (rec_match(w, r)) begin
            sel = FWD_W;
        end else begin
            sel = FWD_RF;
        end
        return sel;
    endfunction

    // E-stage selector: only M and W can feed the ALU operands.
    function automatic logic [1:0] fwd_sel_e(input stage_rec_t m, input stage_rec_t w,
                                             input logic [AW-1:0] r);
        logic [1:0] sel;
        if (rec_match(m, r) && (m.tnew == {TW{1'b0}})) begin
            sel = FWD_M;
        end else if (rec_match(w, r)) begin
            sel = FWD_W;
        end else begin
            sel = FWD_RF;
        end
        return sel;
    endfunction

    assign e_in_s = '{rs: rs_d, rt: rt_d, a3: a3_d, we: we_d, tnew: tnew_d};

    // E record takes the D instruction (tnew already one cycle closer) or a bubble on stall.
    hazard_stage_rec u_rec_e (
        .clk     (clk),
        .reset   (reset),
        .load    (1'b1),
        .bubble  (stall),
        .tnew_op (TNEW_DEC),
        .rec_in  (e_in_s),
        .rec_out (e_rec_s)
    );

    // M record always advances from E.
    hazard_stage_rec u_rec_m (
        .clk     (clk),
        .reset   (reset),
        .load    (1'b1),
        .bubble  (1'b0),
        .tnew_op (TNEW_DEC),
        .rec_in  (e_rec_s),
        .rec_out (m_rec_s)
    );

    // W record always advances from M; every result is ready by write-back.
    hazard_stage_rec u_rec_w (
        .clk     (clk),
        .reset   (reset),
        .load    (1'b1),
        .bubble  (1'b0),
        .tnew_op (TNEW_CLR),
        .rec_in  (m_rec_s),
        .rec_out (w_rec_s)
    );

    // Stall when an operand is needed before an E or M producer has its result.
    always_comb begin
        stall_rs_s = 1'b0;
        stall_rt_s = 1'b0;
        if (use_rs_d) begin
            stall_rs_s = (rec_match(e_rec_s, rs_d) && (tuse_d < e_rec_s.tnew)) ||
                         (rec_match(m_rec_s, rs_d) && (tuse_d < m_rec_s.tnew));
        end else begin
            stall_rs_s = 1'b0;
        end
        if (use_rt_d) begin
            stall_rt_s = (rec_match(e_rec_s, rt_d) && (tuse_d < e_rec_s.tnew)) ||
                         (rec_match(m_rec_s, rt_d) && (tuse_d < m_rec_s.tnew));
        end else begin
            stall_rt_s = 1'b0;
        end
        stall = stall_rs_s || stall_rt_s;
    end

    // Forward selects for the D comparator/jr operands and the E ALU operands.
    always_comb begin
        fwd_rs_d = fwd_sel_d(e_rec_s, m_rec_s, w_rec_s, rs_d);
        fwd_rt_d = fwd_sel_d(e_rec_s, m_rec_s, w_rec_s, rt_d);
        fwd_rs_e = fwd_sel_e(m_rec_s, w_rec_s, e_rec_s.rs);
        fwd_rt_e = fwd_sel_e(m_rec_s, w_rec_s, e_rec_s.rt);
    end

    // Source fields of M/W and W's tnew are carried for completeness but not consulted.
    logic unused_rec_bits_s;
    assign unused_rec_bits_s = ^{m_rec_s.rs, m_rec_s.rt, w_rec_s.rs, w_rec_s.rt, w_rec_s.tnew};

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: the stimulus side predicts outputs with an
// age-based pipeline model; a monitor pops and compares each cycle.
module tb_hazard_ctrl;

    logic       clk;
    logic       reset;
    logic [4:0] rs_d, rt_d, a3_d;
    logic       use_rs_d, use_rt_d, we_d;
    logic [1:0] tuse_d, tnew_d;
    logic       stall;
    logic [1:0] fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e;

    hazard_ctrl dut (
        .clk(clk), .reset(reset),
        .rs_d(rs_d), .rt_d(rt_d), .use_rs_d(use_rs_d), .use_rt_d(use_rt_d),
        .tuse_d(tuse_d), .tnew_d(tnew_d), .we_d(we_d), .a3_d(a3_d),
        .stall(stall), .fwd_rs_d(fwd_rs_d), .fwd_rt_d(fwd_rt_d),
        .fwd_rs_e(fwd_rs_e), .fwd_rt_e(fwd_rt_e)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       urs;
        logic       urt;
        logic [1:0] tuse;
        logic [1:0] tnew;
        logic       we;
        logic [4:0] a3;
    } instr_t;

    typedef struct packed {
        logic       stall;
        logic [1:0] frs_d;
        logic [1:0] frt_d;
        logic [1:0] frs_e;
        logic [1:0] frt_e;
    } exp_t;

    exp_t   exp_q[$];
    instr_t hist[3];   // hist[k] = instruction that left D k+1 cycles ago
    int     n_checks = 0;
    int     n_fail   = 0;
    event   probe_ev;

    function automatic instr_t mk(int rs, int rt, bit urs, bit urt, int tuse, int tnew,
                                  bit we, int a3);
        instr_t i;
        i.rs = rs[4:0]; i.rt = rt[4:0]; i.urs = urs; i.urt = urt;
        i.tuse = tuse[1:0]; i.tnew = tnew[1:0]; i.we = we; i.a3 = a3[4:0];
        return i;
    endfunction

    // Cycles still needed before a producer of the given age has its result.
    function automatic int remaining(instr_t h, int age);
        int v;
        v = int'(h.tnew) - age;
        return (v < 0) ? 0 : v;
    endfunction

    function automatic bit produces(instr_t h, logic [4:0] r);
        return h.we && (h.a3 == r) && (r != 5'd0);
    endfunction

    function automatic bit needs_wait(logic [4:0] r, int tuse);
        bit w;
        w = 1'b0;
        for (int a = 0; a < 2; a++)
            if (produces(hist[a], r) && tuse < remaining(hist[a], a + 1)) w = 1'b1;
        return w;
    endfunction

    // Source code = age of the youngest producer whose value already exists.
    function automatic logic [1:0] src_of(logic [4:0] r, int first_age);
        for (int a = first_age; a <= 3; a++)
            if (produces(hist[a-1], r) && remaining(hist[a-1], a) == 0) return 2'(a);
        return 2'd0;
    endfunction

    function automatic exp_t predict(instr_t ins);
        exp_t e;
        e.stall = (ins.urs && needs_wait(ins.rs, int'(ins.tuse))) ||
                  (ins.urt && needs_wait(ins.rt, int'(ins.tuse)));
        e.frs_d = src_of(ins.rs, 1);
        e.frt_d = src_of(ins.rt, 1);
        e.frs_e = src_of(hist[0].rs, 2);
        e.frt_e = src_of(hist[0].rt, 2);
        return e;
    endfunction

    function automatic void advance(instr_t into_e);
        hist[2] = hist[1];
        hist[1] = hist[0];
        hist[0] = into_e;
    endfunction

    function automatic void clear_model();
        for (int k = 0; k < 3; k++) hist[k] = '0;
    endfunction

    task automatic apply(instr_t ins);
        rs_d = ins.rs; rt_d = ins.rt; use_rs_d = ins.urs; use_rt_d = ins.urt;
        tuse_d = ins.tuse; tnew_d = ins.tnew; we_d = ins.we; a3_d = ins.a3;
    endtask

    // One cycle with ins in D; entered at posedge+1, returns at next posedge+1.
    task automatic drive(instr_t ins, output bit stalled);
        exp_t e;
        apply(ins);
        e = predict(ins);
        exp_q.push_back(e);
        @(posedge clk);
        advance(e.stall ? instr_t'('0) : ins);
        stalled = e.stall;
        #1;
    endtask

    // Hold an instruction in D until it is accepted.
    task automatic issue(instr_t ins);
        bit st;
        int n;
        n = 0;
        do begin
            drive(ins, st);
            n++;
        end while (st && n < 4);
    endtask

    task automatic check(string name, logic [1:0] act, logic [1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Monitor: outputs are presented every cycle; compare at negedge or on a probe.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk or probe_ev);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("stall", {1'b0, stall}, {1'b0, e.stall});
                if (!e.stall) begin
                    check("fwd_rs_d", fwd_rs_d, e.frs_d);
                    check("fwd_rt_d", fwd_rt_d, e.frt_d);
                    check("fwd_rs_e", fwd_rs_e, e.frs_e);
                    check("fwd_rt_e", fwd_rt_e, e.frt_e);
                end
            end
        end
    end

    // Stimulus: reset state, the directed pipeline scenarios, then random traffic.
    initial begin
        instr_t nop, cur;
        bit     st;
        int     k;
        nop = mk(0, 0, 0, 0, 3, 0, 0, 0);
        reset = 1'b1;
        apply(nop);
        clear_model();
        #1;
        exp_q.push_back(predict(nop));
        @(negedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        advance(nop);
        #1;

        // lw $1 ; add $2,$1,$3 (tuse 1) -> one stall, then E forward from W
        issue(mk(0, 0, 0, 0, 3, 3, 1, 1));
        issue(mk(1, 3, 1, 1, 1, 2, 1, 2));
        issue(nop);
        issue(nop);
        // add $4 ; beq $4,$0 -> one stall, then D forward from M
        issue(mk(5, 6, 1, 1, 1, 2, 1, 4));
        issue(mk(4, 0, 1, 1, 0, 0, 0, 0));
        issue(nop);
        // jal ; jr $31 -> no stall, D forward from E
        issue(mk(0, 0, 0, 0, 3, 0, 1, 31));
        issue(mk(31, 0, 1, 0, 0, 0, 0, 0));
        issue(nop);
        // writes to $0 followed by readers of $0
        issue(mk(0, 0, 0, 0, 3, 3, 1, 0));
        issue(mk(0, 0, 1, 1, 0, 2, 1, 0));
        issue(mk(0, 0, 1, 1, 0, 0, 0, 0));
        issue(nop);
        // add $7 ; ori $7 ; nop ; read $7 -> M beats W
        issue(mk(1, 2, 1, 1, 1, 2, 1, 7));
        issue(mk(3, 0, 1, 0, 1, 2, 1, 7));
        issue(nop);
        issue(mk(7, 7, 1, 1, 1, 2, 1, 8));
        issue(nop);
        issue(nop);

        // lw $1 in E, dependent reader stalls, reset pulsed between clock edges
        issue(mk(0, 0, 0, 0, 3, 3, 1, 1));
        cur = mk(1, 0, 1, 0, 0, 2, 1, 2);
        apply(cur);
        exp_q.push_back(predict(cur));
        @(negedge clk);
        #1 reset = 1'b1;
        clear_model();
        exp_q.push_back(predict(cur));
        #1 -> probe_ev;
        #1 reset = 1'b0;
        @(posedge clk);
        advance(cur);
        #1;
        issue(mk(1, 1, 1, 1, 0, 0, 0, 0));
        issue(nop);
        issue(nop);

        // randomized traffic over a small register window to provoke hazards
        st = 1'b0;
        cur = nop;
        for (int i = 0; i < 400; i++) begin
            if (!st) begin
                cur.rs   = 5'($urandom_range(7, 0));
                cur.rt   = 5'($urandom_range(7, 0));
                cur.urs  = 1'($urandom_range(1, 0));
                cur.urt  = 1'($urandom_range(1, 0));
                cur.tuse = 2'($urandom_range(3, 0));
                cur.tnew = 2'($urandom_range(3, 0));
                cur.we   = 1'($urandom_range(1, 0));
                cur.a3   = 5'($urandom_range(7, 0));
            end
            drive(cur, st);
        end

        k = 0;
        while (exp_q.size() != 0 && k < 5) begin
            @(negedge clk);
            #1 k++;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
